// File: rtl/float_to_fixed.sv
// float_to_fixed
//   Iterative converter from {sign, biased exponent, hidden-one mantissa}
//   floating point to a signed two's-complement fixed-point word with N_FRAC
//   fractional bits. Alignment moves the significand one bit per cycle.
//   Special and out-of-range inputs take a one-edge early exit.
//
//   Optional feature macro: CBF_F2FIX_ROUND_EN
//     defined     : round to nearest, ties to even, using guard/sticky bits
//     not defined : truncate the magnitude toward zero (no guard/sticky)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_data    {sign, exp, mant}
//   in_valid   input word present
//   in_ready   converter idle and accepting
//   out_data   signed fixed-point result
//   out_sat    result was clamped (Inf or overflow)
//   out_nan    input was NaN (result forced to 0)
//   out_valid  result present
//   out_ready  consumer accepts
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 OUTPUT)
//
// Handshake: a word moves on a rising edge where valid and ready are both
// high. The producer holds data stable while valid is high and ready is
// low; valid never waits on ready. in_ready is high only in IDLE, out_valid
// only in OUTPUT, so exactly one conversion is in flight.
module float_to_fixed #(
  parameter int N_EXP  = 8,
  parameter int N_MANT = 23,
  parameter int N_OUT  = 16,
  parameter int N_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_EXP+N_MANT:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_OUT-1:0]      out_data,
  output logic                  out_sat,
  output logic                  out_nan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            dbg_state
);

  localparam int BIAS  = (1 << (N_EXP - 1)) - 1;
  localparam int SIG_W = N_MANT + 1;
  // One spare bit on top so a rounding carry is visible to the clamp.
  localparam int MW    = ((SIG_W > N_OUT) ? SIG_W : N_OUT) + 1;
  localparam int CW    = $clog2(MW + 1) + 1;

  localparam logic [MW-1:0]    POS_LIM = MW'((1 << (N_OUT - 1)) - 1);
  localparam logic [MW-1:0]    NEG_LIM = MW'(1 << (N_OUT - 1));
  localparam logic [N_OUT-1:0] POS_SAT = {1'b0, {(N_OUT-1){1'b1}}};
  localparam logic [N_OUT-1:0] NEG_SAT = {1'b1, {(N_OUT-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [N_OUT-1:0] r_data;
  logic             r_sat;
  logic             r_nan;
  logic             r_sign;
  logic             r_left;
  logic [MW-1:0]    r_mag;
  logic [CW-1:0]    r_cnt;
`ifdef CBF_F2FIX_ROUND_EN
  logic             r_guard;
  logic             r_sticky;
`endif

  // ---------------------------------------------------------------------
  // Input decode and classification
  // ---------------------------------------------------------------------
  logic              w_sign;
  logic [N_EXP-1:0]  w_exp;
  logic [N_MANT-1:0] w_mant;
  assign {w_sign, w_exp, w_mant} = in_data;

  int   w_sh;       // alignment shift, positive = left
  int   w_abs_sh;
  int   w_top;      // bit position the hidden one lands on
  logic w_is_nan;
  logic w_is_inf;
  logic w_is_zero;
  logic w_exact_min;
  logic w_ovf;
  logic w_tiny;

  always_comb begin
    w_sh        = int'(w_exp) - BIAS + N_FRAC - N_MANT;
    w_abs_sh    = (w_sh < 0) ? -w_sh : w_sh;
    w_top       = N_MANT + w_sh;
    w_is_nan    = (&w_exp) & (|w_mant);
    w_is_inf    = (&w_exp) & ~(|w_mant);
    w_is_zero   = ~(|w_exp);
    // -2^(N_OUT-1) is representable even though its magnitude is not.
    w_exact_min = w_sign & ~(|w_mant) & (w_top == N_OUT - 1);
    w_ovf       = (w_top >= N_OUT - 1) & ~w_exact_min;
    // Everything shifts out below the guard position: always zero.
    w_tiny      = (-w_sh > N_MANT + 1);
  end

  // ---------------------------------------------------------------------
  // One alignment step. In IDLE this is the load of the significand; in
  // SHIFT it is one shift. When the step brings the counter to zero the
  // stepped value is finalized on the same edge, so the SHIFT path costs
  // |sh| edges after the accept edge (and sh=0 finalizes at accept).
  // ---------------------------------------------------------------------
  logic [MW-1:0] w_mag_n;
  logic [CW-1:0] w_cnt_n;
  logic          w_sign_n;
`ifdef CBF_F2FIX_ROUND_EN
  logic          w_guard_n;
  logic          w_sticky_n;
`endif

  always_comb begin
    w_mag_n    = r_mag;
    w_cnt_n    = r_cnt;
    w_sign_n   = r_sign;
`ifdef CBF_F2FIX_ROUND_EN
    w_guard_n  = r_guard;
    w_sticky_n = r_sticky;
`endif
    if (r_state == S_IDLE) begin
      w_mag_n    = MW'({1'b1, w_mant});
      w_cnt_n    = CW'(w_abs_sh);
      w_sign_n   = w_sign;
`ifdef CBF_F2FIX_ROUND_EN
      w_guard_n  = 1'b0;
      w_sticky_n = 1'b0;
`endif
    end else begin
      w_cnt_n = r_cnt - 1'b1;
      if (r_left) begin
        w_mag_n = {r_mag[MW-2:0], 1'b0};
      end else begin
        w_mag_n    = {1'b0, r_mag[MW-1:1]};
`ifdef CBF_F2FIX_ROUND_EN
        w_guard_n  = r_mag[0];
        w_sticky_n = r_sticky | r_guard;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Finalize: round, clamp, apply sign
  // ---------------------------------------------------------------------
  logic [MW-1:0]    w_mag_r;
  logic [MW-1:0]    w_lim;
  logic [MW-1:0]    w_mag_c;
  logic             w_fin_sat;
  logic [N_OUT-1:0] w_fin_data;

  always_comb begin
`ifdef CBF_F2FIX_ROUND_EN
    w_mag_r = w_mag_n + MW'(w_guard_n & (w_sticky_n | w_mag_n[0]));
`else
    w_mag_r = w_mag_n;
`endif
    w_lim      = w_sign_n ? NEG_LIM : POS_LIM;
    w_fin_sat  = (w_mag_r > w_lim);
    w_mag_c    = w_fin_sat ? w_lim : w_mag_r;
    // Negating zero yields zero, so a negative zero never escapes.
    w_fin_data = w_sign_n ? (N_OUT'(0) - w_mag_c[N_OUT-1:0]) : w_mag_c[N_OUT-1:0];
  end

  logic w_step_done;
  assign w_step_done = (w_cnt_n == '0);

  // ---------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_sat       <= 1'b0;
      r_nan       <= 1'b0;
      r_sign      <= 1'b0;
      r_left      <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
`ifdef CBF_F2FIX_ROUND_EN
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_sign     <= w_sign;
            r_left     <= (w_sh > 0);
            if (w_is_nan) begin
              r_data <= '0;
              r_sat  <= 1'b0;
              r_nan  <= 1'b1;
            end else if (w_is_inf || (!w_is_zero && w_ovf)) begin
              r_data <= w_sign ? NEG_SAT : POS_SAT;
              r_sat  <= 1'b1;
              r_nan  <= 1'b0;
            end else if (w_is_zero || w_tiny) begin
              r_data <= '0;
              r_sat  <= 1'b0;
              r_nan  <= 1'b0;
            end
            if (w_is_nan || w_is_inf || w_is_zero || w_ovf || w_tiny ||
                w_step_done) begin
              if (!(w_is_nan || w_is_inf || w_is_zero || w_ovf || w_tiny)) begin
                r_data <= w_fin_data;
                r_sat  <= w_fin_sat;
                r_nan  <= 1'b0;
              end
              r_state     <= S_OUTPUT;
              r_out_valid <= 1'b1;
            end else begin
              r_mag    <= w_mag_n;
              r_cnt    <= w_cnt_n;
`ifdef CBF_F2FIX_ROUND_EN
              r_guard  <= w_guard_n;
              r_sticky <= w_sticky_n;
`endif
              r_state  <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (w_step_done) begin
            r_data      <= w_fin_data;
            r_sat       <= w_fin_sat;
            r_nan       <= 1'b0;
            r_state     <= S_OUTPUT;
            r_out_valid <= 1'b1;
          end else begin
            r_mag    <= w_mag_n;
            r_cnt    <= w_cnt_n;
`ifdef CBF_F2FIX_ROUND_EN
            r_guard  <= w_guard_n;
            r_sticky <= w_sticky_n;
`endif
          end
        end

        S_OUTPUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign out_sat   = r_sat;
  assign out_nan   = r_nan;
  assign dbg_state = r_state;

endmodule
